// File: rtl/pc_pkg.sv
// Shared constants, helper function and address type for the fetch stage.
package pc_pkg;

    localparam int unsigned AddrWidth        = 32;
    localparam int unsigned DefaultResetAddr = 0;
    localparam int unsigned DefaultPcInc     = 1;

    // Address type for fetch/decode consumers at the default width.
    typedef logic [AddrWidth-1:0] addr_t;

    // Ceiling log2; clog2(1) == 0.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        while ((32'd1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/return_stack.sv
// Circular return-address stack: push overwrites the oldest entry when full.
module return_stack
    import pc_pkg::*;
#(
    parameter int unsigned RAS_DEPTH  = 4,
    parameter int unsigned ADDR_WIDTH = AddrWidth
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        push,
    input  logic                        pop,
    input  logic                        replace,
    input  logic [ADDR_WIDTH-1:0]       push_data,
    output logic [ADDR_WIDTH-1:0]       top_data,
    output logic [clog2(RAS_DEPTH):0]   count,
    output logic                        full,
    output logic                        empty,
    output logic                        overflow_evt,
    output logic                        underflow_evt
);

    localparam int unsigned PtrW = clog2(RAS_DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    logic [ADDR_WIDTH-1:0] mem_q [RAS_DEPTH];
    logic [PtrW-1:0]       ptr_q, ptr_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic                  wr_en;
    logic [PtrW-1:0]       wr_ptr;

    assign count    = cnt_q;
    assign full     = (cnt_q == CntW'(RAS_DEPTH));
    assign empty    = (cnt_q == '0);
    assign top_data = mem_q[ptr_q];

    // Replace has priority; it nets to a push on an empty stack, never an event.
    assign overflow_evt  = push && !replace && full;
    assign underflow_evt = pop && !replace && empty;

    // Next pointer/count and write port selection.
    always_comb begin
        ptr_d  = ptr_q;
        cnt_d  = cnt_q;
        wr_en  = 1'b0;
        wr_ptr = ptr_q;
        if (replace) begin
            wr_en = 1'b1;
            if (empty) begin
                cnt_d = CntW'(1);
            end
        end else if (push) begin
            ptr_d  = ptr_q + PtrW'(1);
            wr_en  = 1'b1;
            wr_ptr = ptr_q + PtrW'(1);
            if (!full) begin
                cnt_d = cnt_q + CntW'(1);
            end
        end else if (pop && !empty) begin
            ptr_d = ptr_q - PtrW'(1);
            cnt_d = cnt_q - CntW'(1);
        end
    end

    // Pointer and count registers.
    always_ff @(negedge clock or negedge reset) begin
        if (!reset) begin
            ptr_q <= '0;
            cnt_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
        end
    end

    // Entry storage; contents are don't-care after reset.
    always_ff @(negedge clock) begin
        if (wr_en) begin
            mem_q[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/pc_unit.sv
// MIPS fetch program counter with redirect, stall and call/return via a RAS.
module pc_unit
    import pc_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = AddrWidth,
    parameter int unsigned PC_INC     = DefaultPcInc,
    parameter int unsigned RESET_ADDR = DefaultResetAddr,
    parameter int unsigned RAS_DEPTH  = 4
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        pc_stall,
    input  logic                        pc_redirect,
    input  logic                        pc_call,
    input  logic                        pc_return,
    input  logic [ADDR_WIDTH-1:0]       pc_target,
    input  logic                        flag_clear,
    output logic [ADDR_WIDTH-1:0]       instruction_address,
    output logic [ADDR_WIDTH-1:0]       link_address,
    output logic [clog2(RAS_DEPTH):0]   ras_count,
    output logic                        ras_empty,
    output logic                        ras_full,
    output logic                        ras_overflow,
    output logic                        ras_underflow
);

    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic                  ovf_q, ovf_d;
    logic                  unf_q, unf_d;
    logic                  push, pop, replace;
    logic [ADDR_WIDTH-1:0] top_data;
    logic                  ovf_evt, unf_evt;

    assign instruction_address = pc_q;
    assign link_address        = pc_q + ADDR_WIDTH'(PC_INC);
    assign ras_overflow        = ovf_q;
    assign ras_underflow       = unf_q;

    return_stack #(
        .RAS_DEPTH  (RAS_DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ras (
        .clock         (clock),
        .reset         (reset),
        .push          (push),
        .pop           (pop),
        .replace       (replace),
        .push_data     (link_address),
        .top_data      (top_data),
        .count         (ras_count),
        .full          (ras_full),
        .empty         (ras_empty),
        .overflow_evt  (ovf_evt),
        .underflow_evt (unf_evt)
    );

    // Priority mux: stall > return > redirect > sequential; set beats clear on flags.
    always_comb begin
        pc_d    = pc_q;
        push    = 1'b0;
        pop     = 1'b0;
        replace = 1'b0;
        if (pc_stall) begin
            pc_d = pc_q;
        end else if (pc_return) begin
            pc_d = ras_empty ? pc_target : top_data;
            if (pc_call) begin
                replace = 1'b1;
            end else begin
                pop = 1'b1;
            end
        end else if (pc_redirect) begin
            pc_d = pc_target;
            push = pc_call;
        end else begin
            pc_d = pc_q + ADDR_WIDTH'(PC_INC);
        end
        ovf_d = (ovf_q && !flag_clear) || ovf_evt;
        unf_d = (unf_q && !flag_clear) || unf_evt;
    end

    // PC and sticky flag registers, updated on the falling edge.
    always_ff @(negedge clock or negedge reset) begin
        if (!reset) begin
            pc_q  <= ADDR_WIDTH'(RESET_ADDR);
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

endmodule

// File: tb/tb_pc_unit.sv
// Directed, table-driven bench for pc_unit at default parameters.
module tb_pc_unit;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        pc_stall = 1'b0;
    logic        pc_redirect = 1'b0;
    logic        pc_call = 1'b0;
    logic        pc_return = 1'b0;
    logic [31:0] pc_target = '0;
    logic        flag_clear = 1'b0;
    logic [31:0] instruction_address;
    logic [31:0] link_address;
    logic [2:0]  ras_count;
    logic        ras_empty;
    logic        ras_full;
    logic        ras_overflow;
    logic        ras_underflow;

    int tests  = 0;
    int failed = 0;

    typedef struct {
        logic        stall;
        logic        ret;
        logic        redir;
        logic        call;
        logic        fclr;
        logic [31:0] target;
        logic [31:0] exp_pc;
        int          exp_cnt;
        logic        exp_ovf;
        logic        exp_unf;
    } vec_t;

    vec_t vecs[$];

    pc_unit dut (
        .clock               (clock),
        .reset               (reset),
        .pc_stall            (pc_stall),
        .pc_redirect         (pc_redirect),
        .pc_call             (pc_call),
        .pc_return           (pc_return),
        .pc_target           (pc_target),
        .flag_clear          (flag_clear),
        .instruction_address (instruction_address),
        .link_address        (link_address),
        .ras_count           (ras_count),
        .ras_empty           (ras_empty),
        .ras_full            (ras_full),
        .ras_overflow        (ras_overflow),
        .ras_underflow       (ras_underflow)
    );

    always #5 clock = ~clock;

    task automatic add(input logic s, input logic r, input logic d, input logic c,
                       input logic f, input logic [31:0] t, input logic [31:0] pc,
                       input int cnt, input logic ov, input logic un);
        vec_t v;
        v.stall = s; v.ret = r; v.redir = d; v.call = c; v.fclr = f; v.target = t;
        v.exp_pc = pc; v.exp_cnt = cnt; v.exp_ovf = ov; v.exp_unf = un;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] pc, input int cnt,
                         input logic ov, input logic un);
        logic [31:0] exp_link;
        exp_link = pc + 32'd1;
        tests++;
        if (instruction_address !== pc || int'(ras_count) != cnt ||
            ras_empty !== (cnt == 0) || ras_full !== (cnt == 4) ||
            ras_overflow !== ov || ras_underflow !== un || link_address !== exp_link) begin
            failed++;
            $display("FAIL %s: got pc=%h link=%h cnt=%0d empty=%b full=%b ovf=%b unf=%b; want pc=%h link=%h cnt=%0d ovf=%b unf=%b",
                     name, instruction_address, link_address, ras_count, ras_empty, ras_full,
                     ras_overflow, ras_underflow, pc, exp_link, cnt, ov, un);
        end
    endtask

    initial begin
        //  stall ret redir call fclr target  pc  cnt ovf unf
        add(0, 0, 0, 0, 0, 32'h0,  32'd1, 0, 0, 0);
        add(0, 0, 0, 0, 0, 32'h0,  32'd2, 0, 0, 0);
        add(0, 0, 0, 0, 0, 32'h0,  32'd3, 0, 0, 0);
        add(0, 0, 0, 0, 0, 32'h0,  32'd4, 0, 0, 0);
        add(0, 0, 0, 0, 0, 32'h0,  32'd5, 0, 0, 0);
        add(0, 0, 1, 0, 0, 32'd10, 32'd10, 0, 0, 0);
        add(0, 0, 1, 1, 0, 32'd100, 32'd100, 1, 0, 0);   // push 11
        add(0, 1, 0, 0, 0, 32'h0,  32'd11, 0, 0, 0);
        add(0, 0, 1, 0, 0, 32'd0,  32'd0, 0, 0, 0);
        add(0, 0, 1, 1, 0, 32'd1,  32'd1, 1, 0, 0);       // push 1
        add(0, 0, 1, 1, 0, 32'd2,  32'd2, 2, 0, 0);       // push 2
        add(0, 0, 1, 1, 0, 32'd3,  32'd3, 3, 0, 0);       // push 3
        add(0, 0, 1, 1, 0, 32'd4,  32'd4, 4, 0, 0);       // push 4, full
        add(0, 0, 1, 1, 0, 32'd5,  32'd5, 4, 1, 0);       // push 5 over 1
        add(0, 1, 0, 0, 0, 32'h0,  32'd5, 3, 1, 0);
        add(0, 1, 0, 0, 0, 32'h0,  32'd4, 2, 1, 0);
        add(0, 1, 0, 0, 0, 32'h0,  32'd3, 1, 1, 0);
        add(0, 1, 0, 0, 0, 32'h0,  32'd2, 0, 1, 0);
        add(0, 1, 0, 0, 0, 32'h40, 32'h40, 0, 1, 1);      // empty return
        add(0, 0, 0, 0, 1, 32'h0,  32'h41, 0, 0, 0);
        add(0, 0, 1, 1, 0, 32'h80, 32'h80, 1, 0, 0);      // push 0x42
        add(1, 1, 1, 0, 0, 32'h99, 32'h80, 1, 0, 0);
        add(1, 1, 1, 0, 0, 32'h99, 32'h80, 1, 0, 0);
        add(1, 1, 1, 0, 0, 32'h99, 32'h80, 1, 0, 0);
        add(0, 1, 1, 0, 0, 32'h99, 32'h42, 0, 0, 0);      // return beats redirect
        add(0, 1, 0, 0, 0, 32'h10, 32'h10, 0, 0, 1);
        add(1, 0, 0, 0, 1, 32'h0,  32'h10, 0, 0, 0);      // clear during stall
        add(0, 0, 1, 0, 0, 32'd19, 32'd19, 0, 0, 0);
        add(0, 0, 1, 1, 0, 32'h30, 32'h30, 1, 0, 0);      // push 20
        add(0, 1, 0, 1, 0, 32'h0,  32'd20, 1, 0, 0);      // top <= 0x31
        add(0, 1, 0, 0, 0, 32'h0,  32'h31, 0, 0, 0);
        add(0, 1, 1, 1, 0, 32'h50, 32'h50, 1, 0, 0);      // empty call-through, top <= 0x32
        add(0, 1, 0, 0, 0, 32'h0,  32'h32, 0, 0, 0);
        add(0, 0, 0, 1, 0, 32'h77, 32'h33, 0, 0, 0);      // lone call ignored
        add(0, 0, 1, 1, 0, 32'hA0, 32'hA0, 1, 0, 0);
        add(0, 0, 1, 1, 0, 32'hA1, 32'hA1, 2, 0, 0);
        add(0, 0, 1, 1, 0, 32'hA2, 32'hA2, 3, 0, 0);
        add(0, 0, 1, 1, 0, 32'hA3, 32'hA3, 4, 0, 0);
        add(0, 0, 1, 1, 1, 32'hA4, 32'hA4, 4, 1, 0);      // set beats clear
        add(0, 0, 0, 0, 1, 32'h0,  32'hA5, 4, 0, 0);
        add(0, 0, 1, 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4, 0, 0);
        add(0, 0, 0, 0, 0, 32'h0,  32'h0, 4, 0, 0);       // silent wrap

        repeat (2) @(negedge clock);
        @(posedge clock);
        check("reset_state", 32'h0, 0, 0, 0);
        reset = 1'b1;

        foreach (vecs[i]) begin
            pc_stall    = vecs[i].stall;
            pc_return   = vecs[i].ret;
            pc_redirect = vecs[i].redir;
            pc_call     = vecs[i].call;
            flag_clear  = vecs[i].fclr;
            pc_target   = vecs[i].target;
            @(negedge clock);
            #1;
            check($sformatf("vec%0d", i), vecs[i].exp_pc, vecs[i].exp_cnt,
                  vecs[i].exp_ovf, vecs[i].exp_unf);
        end

        // Asynchronous reset between edges with a non-empty stack and overflow set.
        pc_stall = 0; pc_return = 0; pc_redirect = 1; pc_call = 1; flag_clear = 0;
        pc_target = 32'h200;
        @(negedge clock);
        #1;
        check("pre_reset_push", 32'h200, 4, 1, 0);
        pc_redirect = 0; pc_call = 0;
        @(negedge clock);
        #1;
        check("pre_reset_seq", 32'h201, 4, 1, 0);
        @(posedge clock);
        reset = 1'b0;
        #1;
        check("async_reset", 32'h0, 0, 0, 0);
        #2;
        reset = 1'b1;
        @(negedge clock);
        #1;
        check("post_reset_seq", 32'h1, 0, 0, 0);
        // Stack is empty after reset: a return falls back to the target.
        pc_return = 1; pc_target = 32'h123;
        @(negedge clock);
        #1;
        check("post_reset_return", 32'h123, 0, 0, 1);
        pc_return = 0;

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Parametrised program counter for the MIPS fetch stage.
- Supports sequential advance, stall/hold, taken jump/branch redirect, and call/return through an internal return-address stack (RAS).
- Drives the instruction-memory address.
- Sticky overflow/underflow flags expose stack misuse to the debug unit.

Parameters:
- ADDR_WIDTH, 32, width of the PC and all address ports.
- PC_INC, 1, sequential increment (word-addressed instruction memory).
- RESET_ADDR, 0, PC value loaded at reset.
- RAS_DEPTH, 4, return-stack entries; power of two, 2 to 16.

Ports:
- clock  in  1  system clock; all state updates on its falling edge.
- reset  in  1  asynchronous, active-low; 0 = reset asserted.
- pc_stall  in  1  hold PC and RAS unchanged.
- pc_redirect  in  1  load pc_target (jump or taken branch).
- pc_call  in  1  with pc_redirect: push link_address onto RAS.
- pc_return  in  1  pop RAS and load popped value.
- pc_target  in  ADDR_WIDTH  redirect target; also the fallback for a return on an empty RAS.
- flag_clear  in  1  clears sticky flags.
- instruction_address  out  ADDR_WIDTH  current PC.
- link_address  out  ADDR_WIDTH  instruction_address + PC_INC, combinational.
- ras_count  out  $clog2(RAS_DEPTH)+1  valid entries.
- ras_empty  out  1  ras_count == 0.
- ras_full  out  1  ras_count == RAS_DEPTH.
- ras_overflow  out  1  sticky: push while full.
- ras_underflow  out  1  sticky: return while empty.

Behaviour:
- Reset (reset = 0, asynchronous, any time including mid-operation):
  - instruction_address = RESET_ADDR, ras_count = 0.
  - Both sticky flags = 0, top pointer = 0; RAS contents don't-care.
- Priority per falling edge, first match wins: pc_stall > pc_return > pc_redirect > sequential.
- pc_stall = 1: PC, RAS, count and pointer are unchanged; other controls are ignored. Sticky flags still clear if flag_clear = 1.
- pc_return = 1, RAS non-empty: PC <= top entry; pop (count - 1).
- pc_return = 1, RAS empty: PC <= pc_target; ras_underflow <= 1; count stays 0.
- pc_return = 1 with pc_call = 1 (call-through-return):
  - PC <= popped top (or pc_target if empty).
  - Top entry is overwritten with link_address; count unchanged, or becomes 1 if it was empty.
  - No underflow on the empty case, since it nets to a push.
  - pc_redirect is ignored.
- pc_redirect = 1, no return: PC <= pc_target. If pc_call = 1, push link_address.
- Push when full: the RAS is circular and overwrites the oldest entry; count stays RAS_DEPTH; ras_overflow <= 1.
- pc_call without pc_redirect or pc_return: ignored; no push.
- Sequential: PC <= PC + PC_INC, truncated to ADDR_WIDTH. Wrap from all-ones to PC_INC-1 is silent; no flag.
- Latency: a control sampled at falling edge N is reflected on instruction_address immediately after edge N; no extra cycle.
- flag_clear:
  - Clears both sticky flags at the edge.
  - If the same edge also sets a flag, the set wins.
- RAS implementation:
  - Pointer-based circular buffer.
  - Push writes at top+1 and advances top; pop reads top and retreats.
  - All pointer arithmetic is modulo RAS_DEPTH.

Decomposition:
- Package pc_pkg:
  - Default RESET_ADDR and PC_INC constants.
  - Shared function clog2.
  - Address typedef (logic [ADDR_WIDTH-1:0]) for fetch/decode consumers.
- One sub-module, return_stack:
  - Parameters RAS_DEPTH and ADDR_WIDTH.
  - Ports: push, pop, replace, push_data, top_data, count, full, empty, overflow_evt, underflow_evt.
  - Owns pointer and count.
- pc_unit holds the PC register, the priority mux and the sticky flags.

Test Plan:
- Reset then 5 edges, no controls → instruction_address 0,1,2,3,4,5; ras_empty = 1.
- PC = 10, pc_redirect + pc_call, pc_target = 100 → PC 100, RAS top 11, count 1. Next edge pc_return → PC 11, count 0.
- 5 calls with RAS_DEPTH = 4, links 1,2,3,4,5 → ras_full = 1, ras_overflow = 1 after the fifth. Then 4 returns → PC 5,4,3,2, count 0. Fifth return with pc_target = 0x40 → PC 0x40, ras_underflow = 1.
- pc_stall asserted together with pc_return and pc_redirect for 3 edges → PC and ras_count unchanged. Release → the return takes effect.
- PC = 0xFFFFFFFF sequential → PC 0x0, no flags. Separately, reset driven low between edges mid-sequence → instruction_address 0 immediately, without a clock edge.
- RAS top 20, pc_return + pc_call → PC 20, count unchanged, top = old PC + 1. flag_clear on the same edge as a new overflow → ras_overflow stays 1.
